// File: rtl/bf16_mul_result_collector.sv
// Collects BF16 multiplier products: classifies each accepted product, queues
// {class, result} in a small FIFO, and keeps sticky exception flags plus an
// accepted-operation counter.
module bf16_mul_result_collector #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_result,
  input  logic             in_zero,
  input  logic             in_underflow,
  input  logic             in_overflow,
  input  logic             in_q_nan,
  input  logic             in_s_nan,
  input  logic             in_pos_inf,
  input  logic             in_neg_inf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic [2:0]       out_class,
  output logic [6:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 19;
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    last_q, last_d;
  logic [6:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [2:0]       in_class;
  logic [6:0]       in_flags;
  logic [EW-1:0]    head;
  logic             full, push, pop;

  assign in_flags = {in_s_nan, in_q_nan, in_neg_inf, in_pos_inf, in_overflow, in_underflow,
                     in_zero};

  // Priority-encode the incoming flags into a class code.
  always_comb begin
    in_class = 3'd0;
    if (in_s_nan)          in_class = 3'd6;
    else if (in_q_nan)     in_class = 3'd5;
    else if (in_neg_inf)   in_class = 3'd4;
    else if (in_pos_inf)   in_class = 3'd3;
    else if (in_overflow)  in_class = 3'd2;
    else if (in_underflow) in_class = 3'd1;
    else if (in_zero)      in_class = 3'd7;
  end

  // in_ready depends only on registered occupancy; rst forces it low.
  assign full      = (count_q == FullCnt);
  assign in_ready  = !rst && !full;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  // When empty, outputs show the last entry that left the FIFO (0 after reset).
  assign {out_class, out_result} = out_valid ? head : last_q;
  assign sticky_flags = sticky_q;
  assign op_count     = op_count_q;

  // Next-state for pointers, occupancy, hold register, sticky flags and counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_d     = last_q;
    sticky_d   = sticky_q;
    op_count_d = op_count_q;
    if (push) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      op_count_d = op_count_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = head;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    // A same-cycle accept wins over the clear: result is exactly its flags.
    if (push)            sticky_d = sticky_clr ? in_flags : (sticky_q | in_flags);
    else if (sticky_clr) sticky_d = '0;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
      sticky_q   <= '0;
      op_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_class, in_result};
  end

endmodule

// File: tb/tb_bf16_mul_result_collector.sv
// Scoreboard bench for bf16_mul_result_collector.
module tb_bf16_mul_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, sticky_clr;
  logic [15:0] in_result, out_result, op_count;
  logic [6:0]  flags, sticky_flags;
  logic [2:0]  out_class;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [18:0] sb[$];
  logic [18:0] exp_e;
  logic [6:0]  exp_sticky;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  bf16_mul_result_collector #(.DEPTH(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_zero      (flags[0]),
    .in_underflow (flags[1]),
    .in_overflow  (flags[2]),
    .in_pos_inf   (flags[3]),
    .in_neg_inf   (flags[4]),
    .in_q_nan     (flags[5]),
    .in_s_nan     (flags[6]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_class    (out_class),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .op_count     (op_count)
  );

  function automatic logic [2:0] cls(input logic [6:0] f);
    if (f[6]) return 3'd6;
    if (f[5]) return 3'd5;
    if (f[4]) return 3'd4;
    if (f[3]) return 3'd3;
    if (f[2]) return 3'd2;
    if (f[1]) return 3'd1;
    if (f[0]) return 3'd7;
    return 3'd0;
  endfunction

  // Monitor away from the active edge: record accepts, check every pop.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_sticky = '0;
      exp_cnt    = '0;
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back({cls(flags), in_result});
        exp_cnt    = exp_cnt + 16'd1;
        exp_sticky = sticky_clr ? flags : (exp_sticky | flags);
      end else if (sticky_clr) begin
        exp_sticky = '0;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected: got %h/%0d, required no output", out_result, out_class);
        end else begin
          exp_e = sb.pop_front();
          if ({out_class, out_result} !== exp_e) begin
            n_err++;
            $display("FAIL pop_data: got %0d/%h, required %0d/%h",
                     out_class, out_result, exp_e[18:16], exp_e[15:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] r, input logic [6:0] f);
    in_valid  = 1'b1;
    in_result = r;
    flags     = f;
    tick();
    in_valid  = 1'b0;
    flags     = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; out_ready = 0; sticky_clr = 0; in_result = '0; flags = '0;
    tick(); tick();
    n_cmp++;
    if ({in_ready, out_valid, sticky_flags, op_count, out_result, out_class} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b st=%b cnt=%h res=%h cls=%0d, required all 0",
               in_ready, out_valid, sticky_flags, op_count, out_result, out_class);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    push_one(16'h3FC0, 7'b0000000);
    push_one(16'h0000, 7'b0000001);
    push_one(16'h7F80, 7'b0001000);
    n_cmp++;
    if ({dut.count_q, out_class, out_result} !== {3'd3, 3'd0, 16'h3FC0}) begin
      n_err++;
      $display("FAIL basic_head: got occ=%0d %0d/%h, required occ=3 0/3fc0",
               dut.count_q, out_class, out_result);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, op_count, sticky_flags} !== {1'b0, 16'd3, 7'b0001001}) begin
      n_err++;
      $display("FAIL basic_end: got vld=%b cnt=%0d st=%b, required 0 3 0001001",
               out_valid, op_count, sticky_flags);
    end
    n_cmp++;
    if ({out_class, out_result} !== {3'd3, 16'h7F80}) begin
      n_err++;
      $display("FAIL empty_hold: got %0d/%h, required 3/7f80", out_class, out_result);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push_one(16'h1000 + 16'(i), 7'(1 << i));
    in_valid = 1'b1; in_result = 16'h4000; flags = '0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({in_ready, dut.count_q} !== {1'b0, 3'd4}) begin
        n_err++;
        $display("FAIL full_block: got rdy=%b occ=%0d, required 0 4", in_ready, dut.count_q);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, dut.count_q} !== {1'b1, 3'd3}) begin
      n_err++;
      $display("FAIL full_release: got rdy=%b occ=%0d, required 1 3", in_ready, dut.count_q);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, out_result} !== {1'b0, 16'h4000}) begin
      n_err++;
      $display("FAIL full_drain: got vld=%b last=%h, required 0 4000", out_valid, out_result);
    end
  endtask

  task automatic test_back_to_back();
    push_one(16'hA000, 7'b0);
    push_one(16'hA001, 7'b0000010);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_result = 16'hB000 + 16'(i);
      flags     = 7'($urandom_range(0, 127));
      tick();
      n_cmp++;
      if (dut.count_q !== 3'd2) begin
        n_err++; $display("FAIL b2b_occ: got %0d, required 2", dut.count_q);
      end
    end
    in_valid = 1'b0; flags = '0;
    repeat (2) tick();
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, sticky_flags, op_count} !== {1'b0, exp_sticky, exp_cnt}) begin
      n_err++;
      $display("FAIL b2b_state: got vld=%b st=%b cnt=%0d, required 0 %b %0d",
               out_valid, sticky_flags, op_count, exp_sticky, exp_cnt);
    end
  endtask

  task automatic test_sticky();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    n_cmp++;
    if (sticky_flags !== 7'b0) begin
      n_err++; $display("FAIL sticky_clr: got %b, required 0", sticky_flags);
    end
    push_one(16'hFF81, 7'b1100000);
    n_cmp++;
    if ({out_class, sticky_flags} !== {3'd6, 7'b1100000}) begin
      n_err++;
      $display("FAIL nan_class: got cls=%0d st=%b, required 6 1100000", out_class, sticky_flags);
    end
    sticky_clr = 1'b1;
    push_one(16'h7F80, 7'b0000100);
    sticky_clr = 1'b0;
    n_cmp++;
    if (sticky_flags !== 7'b0000100) begin
      n_err++; $display("FAIL clr_vs_accept: got %b, required 0000100", sticky_flags);
    end
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_result = 16'h3F80; flags = '0;
    repeat (65535) tick();
    in_valid = 1'b0;
    n_cmp++;
    if (op_count !== 16'hFFFF) begin
      n_err++; $display("FAIL cnt_max: got %h, required ffff", op_count);
    end
    push_one(16'h3F81, 7'b0);
    n_cmp++;
    if (op_count !== 16'h0000) begin
      n_err++; $display("FAIL cnt_wrap: got %h, required 0000", op_count);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    push_one(16'hC001, 7'b0000010);
    push_one(16'hC002, 7'b0001000);
    out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, sticky_flags, op_count} !== '0) begin
      n_err++;
      $display("FAIL async_rst: got vld=%b rdy=%b st=%b cnt=%h, required all 0",
               out_valid, in_ready, sticky_flags, op_count);
    end
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b0;
    push_one(16'h1234, 7'b0);
    n_cmp++;
    if ({out_valid, out_class, out_result, dut.count_q} !== {1'b1, 3'd0, 16'h1234, 3'd1}) begin
      n_err++;
      $display("FAIL post_rst: got vld=%b %0d/%h occ=%0d, required 1 0/1234 1",
               out_valid, out_class, out_result, dut.count_q);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if ((out_valid !== 1'b0) || (sb.size() != 0)) begin
      n_err++;
      $display("FAIL final_empty: got vld=%b pending=%0d, required 0 0", out_valid, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_sticky();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
